// File: rtl/gsched_pkg.sv
// Shared types and helpers for the Gaussian bank scheduler.
package gsched_pkg;

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } gsched_state_t;

  // Width needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/gsched_dog_unit.sv
// One saturating difference hi - lo, clamped to the signed DATA_W range.
// Instantiated by gauss_bank_scheduler only when GSCHED_DOG_EN is defined.
module gsched_dog_unit
  import gsched_pkg::*;
#(
  parameter int unsigned DATA_W = 9
) (
  input  logic [DATA_W-1:0] i_hi,
  input  logic [DATA_W-1:0] i_lo,
  output logic [DATA_W-1:0] o_diff
);

  logic signed [DATA_W:0] w_diff;

  assign w_diff = $signed({i_hi[DATA_W-1], i_hi}) - $signed({i_lo[DATA_W-1], i_lo});

  // Overflow iff the extra sign bit disagrees with the DATA_W sign bit.
  always_comb begin
    o_diff = w_diff[DATA_W-1:0];
    if (w_diff[DATA_W] != w_diff[DATA_W-1])
      o_diff = w_diff[DATA_W] ? DATA_W'(sat_min(DATA_W)) : DATA_W'(sat_max(DATA_W));
  end

endmodule

// File: rtl/gauss_bank_scheduler.sv
// Shares one Gaussian MAC across N_SCALE kernels and publishes the result bank.
// Optional GSCHED_DOG_EN adds a registered, saturated DoG output (latency +1).
module gauss_bank_scheduler
  import gsched_pkg::*;
#(
  parameter int unsigned N_SCALE = 5,
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned MAC_LAT = 3
) (
  input  logic                          pixClk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          pix_en,
  output logic                          mac_issue,
  output logic [idx_w(N_SCALE)-1:0]     mac_sel,
  input  logic                          mac_res_valid,
  input  logic [DATA_W-1:0]             mac_res,
  output logic [N_SCALE*DATA_W-1:0]     scale_out,
  output logic                          scale_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic                          spurious
`ifdef GSCHED_DOG_EN
  ,
  output logic [(N_SCALE-1)*DATA_W-1:0] dog_out
`endif
);

  localparam int unsigned SEL_W = idx_w(N_SCALE);
  localparam int unsigned CNT_W = idx_w(N_SCALE + 1);
  localparam int unsigned FL_W  = idx_w(MAC_LAT + 1);

  gsched_state_t               r_state;
  logic [FL_W-1:0]             r_flush_cnt;
  logic [CNT_W-1:0]            r_ret_cnt;
  logic                        r_pending;
  logic [DATA_W-1:0]           r_bank [N_SCALE];
  logic [N_SCALE*DATA_W-1:0]   r_scale;
  logic                        r_strobe;

  logic                        w_ret_ok;
  logic                        w_take;
  logic                        w_last;
  logic                        w_spur_evt;
  logic                        w_ovr_evt;
  logic [N_SCALE*DATA_W-1:0]   w_bank_next;

  assign w_ret_ok   = ((r_state == S_ISSUE) || (r_state == S_DRAIN)) &&
                      (r_ret_cnt < CNT_W'(N_SCALE));
  assign w_take     = mac_res_valid && w_ret_ok;
  assign w_last     = w_take && (r_ret_cnt == CNT_W'(N_SCALE - 1));
  assign w_spur_evt = mac_res_valid && (r_state != S_FLUSH) && !w_ret_ok;
  assign w_ovr_evt  = pix_en && r_pending;
  assign busy       = (r_state != S_IDLE);

  // Bank image including the result arriving this cycle, for the final load.
  always_comb begin
    w_bank_next = '0;
    for (int unsigned i = 0; i < N_SCALE; i++)
      w_bank_next[i*DATA_W +: DATA_W] = (i == r_ret_cnt) ? mac_res : r_bank[i];
  end

  always_ff @(posedge pixClk) begin
    if (rst) begin
      r_state     <= S_FLUSH;
      r_flush_cnt <= '0;
      r_ret_cnt   <= '0;
      r_pending   <= 1'b0;
      r_scale     <= '0;
      r_strobe    <= 1'b0;
      mac_issue   <= 1'b0;
      mac_sel     <= '0;
      overrun     <= 1'b0;
      spurious    <= 1'b0;
    end else begin
      overrun  <= w_ovr_evt  | (overrun  & ~clear);
      spurious <= w_spur_evt | (spurious & ~clear);
      r_strobe <= 1'b0;

      if (pix_en && (r_state != S_IDLE))
        r_pending <= 1'b1;

      if (w_take) begin
        r_bank[SEL_W'(r_ret_cnt)] <= mac_res;
        r_ret_cnt                 <= r_ret_cnt + 1'b1;
      end

      case (r_state)
        S_FLUSH: begin
          if (r_flush_cnt == FL_W'(MAC_LAT - 1)) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        // A pixel held over from FLUSH is served here; pix_en alongside it is dropped.
        S_IDLE: begin
          if (r_pending || pix_en) begin
            r_state   <= S_ISSUE;
            r_pending <= 1'b0;
            r_ret_cnt <= '0;
            mac_issue <= 1'b1;
            mac_sel   <= '0;
          end
        end
        S_ISSUE: begin
          if (mac_sel == SEL_W'(N_SCALE - 1)) begin
            mac_issue <= 1'b0;
            r_state   <= S_DRAIN;
          end else begin
            mac_sel <= mac_sel + 1'b1;
          end
        end
        S_DRAIN: ;
        S_DONE: begin
          r_ret_cnt <= '0;
          if (r_pending) begin
            r_state   <= S_ISSUE;
            r_pending <= 1'b0;
            mac_issue <= 1'b1;
            mac_sel   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_FLUSH;
      endcase

      if (w_last) begin
        r_scale  <= w_bank_next;
        r_strobe <= 1'b1;
        r_state  <= S_DONE;
      end
    end
  end

`ifdef GSCHED_DOG_EN
  logic [(N_SCALE-1)*DATA_W-1:0] w_dog;

  for (genvar gi = 0; gi < N_SCALE - 1; gi++) begin : g_dog
    gsched_dog_unit #(.DATA_W(DATA_W)) u_dog (
      .i_hi   (r_scale[(gi+1)*DATA_W +: DATA_W]),
      .i_lo   (r_scale[gi*DATA_W +: DATA_W]),
      .o_diff (w_dog[gi*DATA_W +: DATA_W])
    );
  end

  // Output stage keeps scale_out, dog_out and scale_valid aligned.
  always_ff @(posedge pixClk) begin
    if (rst) begin
      scale_out   <= '0;
      dog_out     <= '0;
      scale_valid <= 1'b0;
    end else begin
      scale_out   <= r_scale;
      dog_out     <= w_dog;
      scale_valid <= r_strobe;
    end
  end
`else
  assign scale_out   = r_scale;
  assign scale_valid = r_strobe;
`endif

endmodule

// File: doc/gauss_bank_scheduler.md
# gauss_bank_scheduler

Time-multiplexes one shared Gaussian MAC engine across all scale kernels of the SIFT scale-space bank, instead of instantiating one MAC per scale. For every pixel window accepted from the vertical shift-register window, it issues one MAC operation per scale with the kernel select. It then collects the in-order results into a per-scale result bank and publishes the full bank with a single-cycle valid strobe. It sits between the window/downsample enable logic and the DoG/BMP writer stages.

## Interface
- N_SCALE, 5, number of Gaussian kernels/scales (≥2)
- DATA_W, 9, signed width of one MAC result
- MAC_LAT, 3, MAC latency: issue sampled at edge e → result valid sampled at edge e+MAC_LAT; also flush length after reset
- pixClk  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-high
- clear  in  1  clears sticky error flags
- pix_en  in  1  new window available (the downsampled pixel enable)
- mac_issue  out  1  start one MAC operation
- mac_sel  out  $clog2(N_SCALE)  kernel index for the issued operation
- mac_res_valid  in  1  MAC result valid
- mac_res  in  DATA_W  signed MAC result
- scale_out  out  N_SCALE*DATA_W  result bank; scale i at [i*DATA_W +: DATA_W]
- scale_valid  out  1  one-cycle strobe: scale_out holds a complete pixel
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: pix_en dropped
- spurious  out  1  sticky: mac_res_valid with no operation outstanding

## Operation
- States: FLUSH → IDLE → ISSUE → DRAIN → DONE → (ISSUE if pending, else IDLE).
- FLUSH: entered on rst. Lasts MAC_LAT cycles. mac_res_valid is discarded silently.
- IDLE: pix_en sampled high → ISSUE with issue index 0.
- ISSUE: mac_issue=1 for exactly N_SCALE consecutive cycles. mac_sel runs 0,1,…,N_SCALE-1. Then → DRAIN.
- Results return in issue order. Each sampled mac_res_valid writes bank[ret_cnt] and increments ret_cnt. Returns may start during ISSUE.
- Last return (ret_cnt = N_SCALE-1) → scale_out loads the full bank, including that result. scale_valid is registered high. The state passes through DONE for that cycle.
- Pending: pix_en sampled in any non-IDLE state sets a one-deep pending flag. This includes pix_en in FLUSH and pix_en in the cycle the last result returns.
- pix_en while pending is already set → overrun=1 and the pixel is dropped.
- DONE with pending set → clear pending and go to ISSUE. The next issue index 0 comes on the following cycle.
- mac_res_valid in IDLE, DONE, or after ret_cnt reached N_SCALE → spurious=1 and the result is ignored.
- clear=1 zeroes overrun and spurious. A simultaneous set event wins.
- rst mid-pixel: abandons the pixel, drops pending, and goes to FLUSH. In-flight results are discarded and do not set spurious.

## Timing
- Reset values:
  - state=FLUSH, mac_issue=0, mac_sel=0, scale_out=0, scale_valid=0, busy=1, overrun=0, spurious=0; also dog_out=0 when GSCHED_DOG_EN is defined.
  - ret_cnt=0, pending=0.
- pix_en sampled at edge 0 → mac_issue high after edges 0..N_SCALE-1.
- With an ideal MAC, results are sampled at edges MAC_LAT+1 … MAC_LAT+N_SCALE. scale_valid is registered at edge MAC_LAT+N_SCALE.
- Defaults: scale_valid is high in the cycle after edge 8.
- Minimum pixel interval with pending: N_SCALE+MAC_LAT+1 cycles.
- scale_out is stable between strobes.

## Configuration
- GSCHED_DOG_EN defined: adds output dog_out, (N_SCALE-1)*DATA_W wide.
  - dog[i] = saturate(scale[i+1] − scale[i]), computed at DATA_W+1 bits and clamped to the signed DATA_W range.
  - scale_out, dog_out and scale_valid are all delayed one cycle so they stay aligned; latency +1.
- Not defined: no dog_out port and no subtractors. Timing is as stated above.

## Structure
- Package gsched_pkg:
  - state enum (FLUSH, IDLE, ISSUE, DRAIN, DONE);
  - index-width constant function;
  - saturation limits as a function of DATA_W.
- Sub-module gsched_dog_unit (one saturating subtractor, generated N_SCALE-1 times). It exists only under GSCHED_DOG_EN.

## Test plan
- Defaults, MAC model with latency 3 returning 10,20,30,40,50; pix_en at edge 0 → mac_sel 0..4 on consecutive cycles, scale_valid at edge 8, scale_out={50,40,30,20,10}.
- Second pix_en during DRAIN → pending; mac_issue for pixel 2 restarts one cycle after the scale_valid strobe; overrun stays 0.
- Three pix_en pulses within one pixel → overrun=1, exactly two scale_valid strobes. clear → overrun=0.
- Injected mac_res_valid while IDLE → spurious=1, scale_out unchanged, no strobe.
- rst asserted mid-ISSUE with results still in flight → those results are discarded during FLUSH, spurious=0; a fresh pixel completes correctly.
- GSCHED_DOG_EN, scale results 100,−200,0,255,−256 → dog={−256(sat),200,255,−256(sat)}, aligned with scale_valid at edge 9.
